fpu_op_sequencer: RTL and testbench
===================================

Name: fpu_op_sequencer

Overview:
- Upstream/downstream wrapper around the team's 32-bit multi-cycle FPU adder (1 sign, 6 exponent, 25 mantissa bits).
- The FPU has no start/done handshake and samples its operand inputs live. This block therefore accepts operand pairs over valid/ready and holds them stable on the FPU inputs long enough for a clean result.
- It then captures the FPU's data/status into a one-deep result buffer with backpressure, and keeps sticky status and an operation count.

Parameters:
- SETTLE_CYCLES, 80: edges the operands are held before capture. Must be at least 2 full worst-case FPU passes (2 x 36 cycles); legal range 2..255.
- CNT_W, 8: width of the settle counter.
- OPCNT_W, 16: width of the completed-operation counter.

Ports:
- clock100KHz  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  32  operand A.
- in_b  in  32  operand B.
- op_a_out  out  32  registered operand A, driven to the FPU op_A_in.
- op_b_out  out  32  registered operand B, driven to the FPU op_B_in.
- fpu_data_in  in  32  FPU data_out.
- fpu_status_in  in  4  FPU status_out (one-hot: 1000 underflow, 0100 overflow, 0010 inexact, 0001 exact).
- res_valid  out  1  result buffer holds a result.
- res_ready  in  1  consumer accepts the result.
- res_data  out  32  captured result word.
- res_status  out  4  captured status.
- sticky_status  out  4  OR of every res_status captured since the last clear.
- clr_sticky  in  1  synchronous clear of sticky_status and proto_err.
- proto_err  out  1  sticky flag: a captured status was not one-hot.
- busy  out  1  high in SETTLE and CAPTURE.
- op_count  out  OPCNT_W  number of results handed off; wraps modulo 2^OPCNT_W.

Behaviour:
- Reset (asynchronous, reset=0) takes effect at any time, including mid-operation.
  - State returns to IDLE.
  - All outputs and registers are forced to 0 (op_a_out, op_b_out, res_*, sticky_status, proto_err, op_count, counter).
  - Any pending operation or held result is discarded.
- States are IDLE, SETTLE, CAPTURE and RESULT. in_ready = (state==IDLE), decoded combinationally from state. busy = (state==SETTLE or CAPTURE).
- IDLE: on an edge with in_valid=1:
  - op_a_out <= in_a, op_b_out <= in_b.
  - cnt <= SETTLE_CYCLES-1.
  - go to SETTLE.
  - Otherwise stay in IDLE. op_a_out/op_b_out keep their last values; they never change outside this transfer.
- SETTLE: if cnt==0, go to CAPTURE; else cnt <= cnt-1. SETTLE lasts exactly SETTLE_CYCLES edges.
- CAPTURE, one edge:
  - res_data <= fpu_data_in; res_valid <= 1; go to RESULT.
  - If fpu_status_in is one-hot: res_status <= fpu_status_in.
  - If not one-hot: res_status <= 0000 and proto_err <= 1.
  - sticky_status <= (clr_sticky ? 0 : sticky_status) | captured res_status. A new capture in the same cycle as clr_sticky survives the clear.
- RESULT: on an edge with res_ready=1:
  - res_valid <= 0; op_count <= op_count+1; go to IDLE.
  - res_data/res_status keep their values until the next capture.
  - With res_ready=0 the state holds indefinitely.
- Latency: operands are accepted at edge E. res_valid rises at edge E+SETTLE_CYCLES+1. Throughput is one operation per SETTLE_CYCLES+3 edges when res_ready is held high.
- clr_sticky in a cycle without a capture clears sticky_status and proto_err at that edge.
- Simultaneous events:
  - in_valid is ignored outside IDLE; the producer must hold in_a/in_b until in_ready.
  - res_ready is ignored outside RESULT.
- op_count wraps from all-ones to 0 without a flag.

Test Plan:
- Reset released, in_valid=1, in_a=0x02000000, in_b=0x02000000, FPU model returning data 0x04000000 / status 0001 -> op_a_out/op_b_out update at edge 1; res_valid at edge 82; res_data=0x04000000, res_status=0001, op_count=1 after res_ready.
- Backpressure: res_ready=0 for 20 cycles after res_valid -> res_valid stays 1, in_ready stays 0, second in_valid not accepted; res_ready=1 -> IDLE next edge, in_ready=1.
- Sticky: three ops with statuses 0010, 0001, 0100 -> sticky_status=0111; clr_sticky pulsed in the CAPTURE cycle of a 1000 result -> sticky_status=1000.
- Protocol error: fpu_status_in=0110 at capture -> res_status=0000, proto_err=1; clr_sticky -> proto_err=0.
- Reset mid-SETTLE (counter at 40) -> all outputs 0 immediately (asynchronously); after release, a new op completes with full SETTLE_CYCLES latency.
- Wrap: preload op_count to 0xFFFF (OPCNT_W=16), complete one op -> op_count=0x0000.

Source files
------------

// File: rtl/fpu_op_sequencer.sv
// Valid/ready wrapper around the multi-cycle FPU adder: holds operands stable for a
// fixed settle window, captures data/status into a one-deep result buffer with backpressure.
`timescale 1ns/1ps
module fpu_op_sequencer #(
  parameter int SETTLE_CYCLES = 80,
  parameter int CNT_W         = 8,
  parameter int OPCNT_W       = 16
) (
  input  logic               clock100KHz,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_a,
  input  logic [31:0]        in_b,
  output logic [31:0]        op_a_out,
  output logic [31:0]        op_b_out,
  input  logic [31:0]        fpu_data_in,
  input  logic [3:0]         fpu_status_in,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [31:0]        res_data,
  output logic [3:0]         res_status,
  output logic [3:0]         sticky_status,
  input  logic               clr_sticky,
  output logic               proto_err,
  output logic               busy,
  output logic [OPCNT_W-1:0] op_count
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_RESULT  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        op_a_q, op_a_d;
  logic [31:0]        op_b_q, op_b_d;
  logic               res_valid_q, res_valid_d;
  logic [31:0]        res_data_q, res_data_d;
  logic [3:0]         res_status_q, res_status_d;
  logic [3:0]         sticky_q, sticky_d;
  logic               perr_q, perr_d;
  logic [OPCNT_W-1:0] opcnt_q, opcnt_d;
  logic [3:0]         cap_status;
  logic               cap_err;

  function automatic logic is_onehot(input logic [3:0] s);
    return (s != 4'd0) && ((s & (s - 4'd1)) == 4'd0);
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_status_d = res_status_q;
    opcnt_d      = opcnt_q;
    cap_status   = 4'd0;
    cap_err      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_a_d  = in_a;
          op_b_d  = in_b;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_CAPTURE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_CAPTURE: begin
        // A malformed status is recorded as 0000 and flagged rather than passed on.
        if (is_onehot(fpu_status_in)) cap_status = fpu_status_in;
        else                          cap_err    = 1'b1;
        res_data_d   = fpu_data_in;
        res_status_d = cap_status;
        res_valid_d  = 1'b1;
        state_d      = ST_RESULT;
      end
      ST_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          opcnt_d     = opcnt_q + OPCNT_W'(1);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Clear first, then merge: a capture coinciding with the clear is kept.
    sticky_d = (clr_sticky ? 4'd0 : sticky_q) | cap_status;
    perr_d   = (clr_sticky ? 1'b0 : perr_q) | cap_err;
  end

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_status_q <= '0;
      sticky_q     <= '0;
      perr_q       <= 1'b0;
      opcnt_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_status_q <= res_status_d;
      sticky_q     <= sticky_d;
      perr_q       <= perr_d;
      opcnt_q      <= opcnt_d;
    end
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign busy          = (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
  assign op_a_out      = op_a_q;
  assign op_b_out      = op_b_q;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign res_status    = res_status_q;
  assign sticky_status = sticky_q;
  assign proto_err     = perr_q;
  assign op_count      = opcnt_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed bench for fpu_op_sequencer: latency, backpressure, sticky status,
// protocol error, asynchronous reset and op_count wrap (small-width instance).
`timescale 1ns/1ps
module tb_fpu_op_sequencer;

  localparam int S = 80;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0, in_b = '0;
  logic [31:0] op_a_out, op_b_out;
  logic [31:0] fpu_data_in = '0;
  logic [3:0]  fpu_status_in = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic [3:0]  res_status, sticky_status;
  logic        clr_sticky = 1'b0;
  logic        proto_err, busy;
  logic [15:0] op_count;

  // Second instance: minimum settle window and narrow counter to reach the wrap quickly.
  logic        reset2 = 1'b0;
  logic        w_in_ready, w_res_valid, w_proto_err, w_busy;
  logic [31:0] w_op_a, w_op_b, w_res_data;
  logic [3:0]  w_res_status, w_sticky;
  logic [3:0]  w_op_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fpu_op_sequencer #(.SETTLE_CYCLES(S), .CNT_W(8), .OPCNT_W(16)) dut (
    .clock100KHz(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .op_a_out(op_a_out), .op_b_out(op_b_out),
    .fpu_data_in(fpu_data_in), .fpu_status_in(fpu_status_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_status(res_status), .sticky_status(sticky_status), .clr_sticky(clr_sticky),
    .proto_err(proto_err), .busy(busy), .op_count(op_count)
  );

  fpu_op_sequencer #(.SETTLE_CYCLES(2), .CNT_W(8), .OPCNT_W(4)) dut_w (
    .clock100KHz(clk), .reset(reset2), .in_valid(1'b1), .in_ready(w_in_ready),
    .in_a(32'h1), .in_b(32'h2), .op_a_out(w_op_a), .op_b_out(w_op_b),
    .fpu_data_in(32'h3), .fpu_status_in(4'b0001),
    .res_valid(w_res_valid), .res_ready(1'b1), .res_data(w_res_data),
    .res_status(w_res_status), .sticky_status(w_sticky), .clr_sticky(1'b0),
    .proto_err(w_proto_err), .busy(w_busy), .op_count(w_op_count)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Accept one operand pair, run the settle window, then the capture edge
  // (optionally with clr_sticky asserted on it). Leaves the block in RESULT.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] d, input logic [3:0] st, input logic clr_cap);
    in_a = a; in_b = b; fpu_data_in = d; fpu_status_in = st; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(S);
    clr_sticky = clr_cap;
    step(1);
    clr_sticky = 1'b0;
  endtask

  task automatic handoff();
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    total++; if (op_count !== 16'h0) begin bad++; $display("FAIL reset_op_count got %h want 0", op_count); end
    total++; if (sticky_status !== 4'h0) begin bad++; $display("FAIL reset_sticky got %b want 0000", sticky_status); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    in_a = 32'h0200_0000; in_b = 32'h0200_0000;
    fpu_data_in = 32'h0400_0000; fpu_status_in = 4'b0001; in_valid = 1'b1;
    step(1);   // edge 1
    in_valid = 1'b0;
    total++; if (op_a_out !== 32'h0200_0000) begin bad++; $display("FAIL basic_op_a got %h want 02000000", op_a_out); end
    total++; if (op_b_out !== 32'h0200_0000) begin bad++; $display("FAIL basic_op_b got %h want 02000000", op_b_out); end
    total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL basic_busy got busy=%b rdy=%b want 1/0", busy, in_ready); end
    step(S);   // edge 81
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got %b want 0 at edge 81", res_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_capture_busy got %b want 1", busy); end
    step(1);   // edge 82
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got %b want 1 at edge 82", res_valid); end
    total++; if (res_data !== 32'h0400_0000) begin bad++; $display("FAIL basic_data got %h want 04000000", res_data); end
    total++; if (res_status !== 4'b0001) begin bad++; $display("FAIL basic_status got %b want 0001", res_status); end
    total++; if (busy !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL basic_result_state got busy=%b rdy=%b want 0/0", busy, in_ready); end
    handoff();
    total++; if (op_count !== 16'd1) begin bad++; $display("FAIL basic_op_count got %0d want 1", op_count); end
    total++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL basic_idle got vld=%b rdy=%b want 0/1", res_valid, in_ready); end
    total++; if (res_data !== 32'h0400_0000) begin bad++; $display("FAIL basic_data_hold got %h want 04000000", res_data); end
  endtask

  task automatic test_backpressure();
    do_op(32'h1111_1111, 32'h2222_2222, 32'hAAAA_0001, 4'b0010, 1'b0);
    in_valid = 1'b1; in_a = 32'h5555_5555; in_b = 32'h6666_6666;
    for (int i = 0; i < 20; i++) begin
      step(1);
      total++; if (res_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_%0d got vld=%b rdy=%b want 1/0", i, res_valid, in_ready); end
    end
    total++; if (op_a_out !== 32'h1111_1111) begin bad++; $display("FAIL bp_op_a got %h want 11111111", op_a_out); end
    total++; if (res_data !== 32'hAAAA_0001) begin bad++; $display("FAIL bp_data got %h want aaaa0001", res_data); end
    in_valid = 1'b0;
    handoff();
    total++; if (in_ready !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("FAIL bp_release got rdy=%b vld=%b want 1/0", in_ready, res_valid); end
    total++; if (op_count !== 16'd2) begin bad++; $display("FAIL bp_op_count got %0d want 2", op_count); end
    step(2);
    total++; if (in_ready !== 1'b1 || op_b_out !== 32'h2222_2222) begin bad++; $display("FAIL bp_no_accept got rdy=%b op_b=%h want 1/22222222", in_ready, op_b_out); end
  endtask

  task automatic test_sticky();
    clr_sticky = 1'b1;
    step(1);
    clr_sticky = 1'b0;
    total++; if (sticky_status !== 4'b0000) begin bad++; $display("FAIL sticky_clr_idle got %b want 0000", sticky_status); end
    do_op(32'h1, 32'h2, 32'h10, 4'b0010, 1'b0); handoff();
    do_op(32'h3, 32'h4, 32'h20, 4'b0001, 1'b0); handoff();
    do_op(32'h5, 32'h6, 32'h30, 4'b0100, 1'b0);
    total++; if (res_status !== 4'b0100) begin bad++; $display("FAIL sticky_last_status got %b want 0100", res_status); end
    handoff();
    total++; if (sticky_status !== 4'b0111) begin bad++; $display("FAIL sticky_or got %b want 0111", sticky_status); end
    do_op(32'h7, 32'h8, 32'h40, 4'b1000, 1'b1);
    total++; if (sticky_status !== 4'b1000) begin bad++; $display("FAIL sticky_clr_capture got %b want 1000", sticky_status); end
    total++; if (res_status !== 4'b1000) begin bad++; $display("FAIL sticky_uf_status got %b want 1000", res_status); end
    handoff();
    total++; if (op_count !== 16'd6) begin bad++; $display("FAIL sticky_op_count got %0d want 6", op_count); end
  endtask

  task automatic test_proto_err();
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL perr_initial got %b want 0", proto_err); end
    do_op(32'h9, 32'hA, 32'hDEAD_BEEF, 4'b0110, 1'b0);
    total++; if (res_status !== 4'b0000) begin bad++; $display("FAIL perr_status got %b want 0000", res_status); end
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL perr_set got %b want 1", proto_err); end
    total++; if (res_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL perr_data got %h want deadbeef", res_data); end
    total++; if (sticky_status !== 4'b1000) begin bad++; $display("FAIL perr_sticky got %b want 1000", sticky_status); end
    handoff();
    step(3);
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL perr_held got %b want 1", proto_err); end
    clr_sticky = 1'b1;
    step(1);
    clr_sticky = 1'b0;
    total++; if (proto_err !== 1'b0 || sticky_status !== 4'b0000) begin bad++; $display("FAIL perr_clr got perr=%b sticky=%b want 0/0000", proto_err, sticky_status); end
  endtask

  task automatic test_reset_mid();
    in_a = 32'hCAFE_0001; in_b = 32'hCAFE_0002; fpu_data_in = 32'h7777_0000; fpu_status_in = 4'b0100; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(39);  // settle counter now 40
    clr_sticky = 1'b0;
    #2 reset = 1'b0;
    #1;
    total++; if (op_a_out !== 32'h0 || op_b_out !== 32'h0) begin bad++; $display("FAIL rst_mid_ops got %h/%h want 0/0", op_a_out, op_b_out); end
    total++; if (res_data !== 32'h0 || res_status !== 4'h0 || res_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_res got %h/%b/%b want 0", res_data, res_status, res_valid); end
    total++; if (op_count !== 16'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ctrl got cnt=%h busy=%b rdy=%b want 0/0/1", op_count, busy, in_ready); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    in_a = 32'h0000_0ABC; in_b = 32'h0000_0DEF; fpu_data_in = 32'h1234_5678; fpu_status_in = 4'b0010; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    total++; if (op_a_out !== 32'h0000_0ABC) begin bad++; $display("FAIL rst_after_op_a got %h want 00000abc", op_a_out); end
    step(S);
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_after_early got %b want 0", res_valid); end
    step(1);
    total++; if (res_valid !== 1'b1 || res_data !== 32'h1234_5678) begin bad++; $display("FAIL rst_after_valid got %b/%h want 1/12345678", res_valid, res_data); end
    handoff();
    total++; if (op_count !== 16'd1) begin bad++; $display("FAIL rst_after_count got %0d want 1", op_count); end
  endtask

  // in_valid/res_ready held high: one op every SETTLE+3 = 5 edges, op k hands off at edge 5k.
  task automatic test_wrap();
    @(negedge clk);
    reset2 = 1'b1;
    step(74);
    total++; if (w_op_count !== 4'd14) begin bad++; $display("FAIL wrap_edge74 got %0d want 14", w_op_count); end
    step(1);
    total++; if (w_op_count !== 4'hF) begin bad++; $display("FAIL wrap_allones got %h want f", w_op_count); end
    step(5);
    total++; if (w_op_count !== 4'h0) begin bad++; $display("FAIL wrap_zero got %h want 0", w_op_count); end
    total++; if (w_sticky !== 4'b0001 || w_proto_err !== 1'b0) begin bad++; $display("FAIL wrap_status got %b/%b want 0001/0", w_sticky, w_proto_err); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_sticky();
    test_proto_err();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
